n_input_mix_sequencer: RTL

N_INPUT_MIX_SEQUENCER -- requirements
Module: n_input_mix_sequencer

---
 rtl/n_input_mix_sequencer_pkg.sv | 17 +
 rtl/n_input_mix_sequencer_phase_timer.sv | 26 ++
 rtl/n_input_mix_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/n_input_mix_sequencer_pkg.sv
// Shared state encodings and default sizing for the n-input mix sequencer.
package mix_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_DOSE  = 3'd1;
    localparam state_t S_GAP   = 3'd2;
    localparam state_t S_MIX   = 3'd3;
    localparam state_t S_FLUSH = 3'd4;
    localparam state_t S_DONE  = 3'd5;

    localparam int unsigned DEF_N_IN    = 3;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_GAP_CYC = 4;

endpackage

// File: rtl/n_input_mix_sequencer_phase_timer.sv
// Loadable saturating down-counter shared by every timed phase of the sequencer.
module phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/n_input_mix_sequencer.sv
// Doses each enabled inlet in index order, then runs the mixer pump and flush valve.
module n_input_mix_sequencer
    import mix_seq_pkg::*;
#(
    parameter int unsigned N_IN    = DEF_N_IN,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC,
    localparam int unsigned IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [N_IN-1:0]       in_mask,
    input  logic [N_IN*CNT_W-1:0] dose_len,
    input  logic [CNT_W-1:0]      mix_len,
    input  logic [CNT_W-1:0]      flush_len,
    output logic [N_IN-1:0]       valve_open,
    output logic                  pump_on,
    output logic                  flush_open,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [IDX_W-1:0]      cur_idx
);

    state_t                state, nxt_state;
    logic [IDX_W-1:0]      idx, nxt_idx;
    logic                  abort_flush, nxt_af;
    logic                  drop, nxt_drop;
    logic [N_IN-1:0]       mask_q;
    logic [N_IN*CNT_W-1:0] dose_q;
    logic [CNT_W-1:0]      mix_q, flush_q;

    logic                  tmr_load, tmr_expired;
    logic [CNT_W-1:0]      tmr_val;
    logic                  err_d, latch;
    logic [N_IN-1:0]       valve_d;

    logic [N_IN-1:0]       elig_in, elig_q;
    logic                  any_in, adv_next, adv_more;
    logic [IDX_W-1:0]      first_idx;
    logic [CNT_W-1:0]      first_dose, next_dose;
    int unsigned           idx_u;

    // Post-dose decision, shared by DOSE (no gap) and GAP expiry
    state_t                a_state;
    logic [IDX_W-1:0]      a_idx;
    logic                  a_load;
    logic [CNT_W-1:0]      a_val;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_comb begin
        any_in     = 1'b0;
        first_idx  = '0;
        first_dose = '0;
        adv_next   = 1'b0;
        adv_more   = 1'b0;
        next_dose  = '0;
        idx_u      = 32'(idx);
        for (int unsigned i = 0; i < N_IN; i++) begin
            elig_in[i] = in_mask[i] && (dose_len[i*CNT_W +: CNT_W] != '0);
            elig_q[i]  = mask_q[i]  && (dose_q[i*CNT_W +: CNT_W] != '0);
            if (elig_in[i] && !any_in) begin
                any_in     = 1'b1;
                first_idx  = IDX_W'(i);
                first_dose = dose_len[i*CNT_W +: CNT_W];
            end
            if (i == idx_u + 1 && elig_q[i]) begin
                adv_next  = 1'b1;
                next_dose = dose_q[i*CNT_W +: CNT_W];
            end
            if (i > idx_u + 1 && elig_q[i]) begin
                adv_more = 1'b1;
            end
        end

        // An ineligible inlet between two eligible ones costs one scan cycle in GAP
        a_idx  = '0;
        a_load = 1'b0;
        a_val  = '0;
        if (adv_next) begin
            a_state = S_DOSE;
            a_idx   = idx + IDX_W'(1);
            a_load  = 1'b1;
            a_val   = next_dose - CNT_W'(1);
        end else if (adv_more) begin
            a_state = S_GAP;
            a_idx   = idx + IDX_W'(1);
        end else if (mix_q != '0) begin
            a_state = S_MIX;
            a_load  = 1'b1;
            a_val   = mix_q - CNT_W'(1);
        end else if (flush_q != '0) begin
            a_state = S_FLUSH;
            a_load  = 1'b1;
            a_val   = flush_q - CNT_W'(1);
        end else begin
            a_state = S_DONE;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_af    = abort_flush;
        nxt_drop  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        err_d     = 1'b0;
        latch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    latch = 1'b1;
                    if (any_in) begin
                        nxt_state = S_DOSE;
                        nxt_idx   = first_idx;
                        nxt_af    = 1'b0;
                        tmr_load  = 1'b1;
                        tmr_val   = first_dose - CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DOSE: begin
                if (tmr_expired) begin
                    if (GAP_CYC != 0) begin
                        nxt_state = S_GAP;
                        tmr_load  = 1'b1;
                        tmr_val   = CNT_W'(GAP_CYC - 1);
                    end else begin
                        nxt_state = a_state;
                        nxt_idx   = a_idx;
                        tmr_load  = a_load;
                        tmr_val   = a_val;
                    end
                end
            end
            S_GAP: begin
                if (tmr_expired) begin
                    nxt_state = a_state;
                    nxt_idx   = a_idx;
                    tmr_load  = a_load;
                    tmr_val   = a_val;
                end
            end
            S_MIX: begin
                if (tmr_expired) begin
                    if (flush_q != '0) begin
                        nxt_state = S_FLUSH;
                        tmr_load  = 1'b1;
                        tmr_val   = flush_q - CNT_W'(1);
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            S_FLUSH: begin
                if (drop) begin
                    tmr_load = 1'b1;
                    tmr_val  = flush_q - CNT_W'(1);
                end else if (tmr_expired) begin
                    nxt_state = abort_flush ? S_IDLE : S_DONE;
                    nxt_af    = 1'b0;
                end
            end
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase

        // Abort spends one all-closed cycle in FLUSH before the flush timer is loaded
        if (abort && state != S_IDLE && state != S_DONE && !abort_flush) begin
            err_d    = 1'b1;
            tmr_load = 1'b0;
            nxt_idx  = '0;
            if (flush_q != '0) begin
                nxt_state = S_FLUSH;
                nxt_af    = 1'b1;
                nxt_drop  = 1'b1;
            end else begin
                nxt_state = S_IDLE;
                nxt_af    = 1'b0;
            end
        end

        for (int unsigned i = 0; i < N_IN; i++) begin
            valve_d[i] = (nxt_state == S_DOSE) && (i == 32'(nxt_idx));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            abort_flush <= 1'b0;
            drop        <= 1'b0;
            mask_q      <= '0;
            dose_q      <= '0;
            mix_q       <= '0;
            flush_q     <= '0;
            valve_open  <= '0;
            pump_on     <= 1'b0;
            flush_open  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cur_idx     <= '0;
        end else begin
            state       <= nxt_state;
            idx         <= nxt_idx;
            abort_flush <= nxt_af;
            drop        <= nxt_drop;
            if (latch) begin
                mask_q  <= in_mask;
                dose_q  <= dose_len;
                mix_q   <= mix_len;
                flush_q <= flush_len;
            end
            valve_open  <= valve_d;
            pump_on     <= (nxt_state == S_MIX);
            flush_open  <= (nxt_state == S_FLUSH) && !nxt_drop;
            busy        <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
            done        <= (nxt_state == S_DONE);
            err         <= err_d;
            cur_idx     <= (nxt_state == S_DOSE) ? nxt_idx : '0;
        end
    end

endmodule
